int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 29 ++
 rtl/int_ctrl.sv | 172 +++++++++++++++++
 tb/tb_int_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if: the CPU-side bundle of the interrupt controller.
//   master : CPU / control-unit side. It drives the request, commit and eret
//            strobes and the sequential PC, and it receives the redirect and
//            the status.
//   slave  : the int_ctrl block itself.
// -----------------------------------------------------------------------------
interface int_ctrl_if;
   logic        int_req;      // external request, asynchronous to clk
   logic        inst_valid;   // instruction commits this cycle
   logic        eret;         // eret decoded by the control unit
   logic [31:0] pc_next;      // sequential next PC of committing instruction
   logic        int_code;     // CPU is in interrupt service
   logic        int_take;     // one-cycle redirect to the interrupt vector
   logic        eret_take;    // one-cycle redirect to epc
   logic [31:0] pc_redirect;  // redirect target
   logic [31:0] epc;          // saved return PC
   logic [15:0] int_count;    // number of interrupts taken

   modport master (
      output int_req, inst_valid, eret, pc_next,
      input  int_code, int_take, eret_take, pc_redirect, epc, int_count
   );

   modport slave (
      input  int_req, inst_valid, eret, pc_next,
      output int_code, int_take, eret_take, pc_redirect, epc, int_count
   );
endinterface

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl: a single-source, non-nesting interrupt controller for a
// multi-cycle CPU.
//
// The controller synchronises int_req, turns it into an event, and holds that
// event pending until an instruction commits. It then redirects the PC to
// INT_VECTOR and saves the return PC in epc. An eret committed during service
// redirects the PC back to epc. A request that arrives during service is kept
// in a single merged flag and is served right after the eret.
//
// Configuration macro INT_EDGE_EN:
//   defined   - the event is the synchronised rising edge of int_req. A
//               request that stays high gives exactly one interrupt.
//   undefined - level-sensitive. The event is the synchronised level, so a
//               request that is still high at eret re-enters PEND at once.
//
// int_take, eret_take and pc_redirect are combinational from the state and
// the commit strobes. The CPU must act on the redirect in the same cycle that
// the instruction commits.
// -----------------------------------------------------------------------------
module int_ctrl #(
   parameter logic [31:0] INT_VECTOR = 32'h0000_0004
) (
   input  logic      clk,
   input  logic      rst_n,
   int_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   // Synchroniser chain for the asynchronous request.
   logic        s1_q;
   logic        s2_q;
`ifdef INT_EDGE_EN
   logic        s3_q;
`endif

   // Controller state and its next-state values.
   state_e      state_q,     state_d;
   logic        flag_q,      flag_d;
   logic [31:0] epc_q,       epc_d;
   logic [15:0] int_count_q, int_count_d;

   // Decoded event and the combinational redirect outputs.
   logic        req_evt_s;
   logic        int_take_s;
   logic        eret_take_s;
   logic [31:0] pc_redirect_s;

`ifdef INT_EDGE_EN
   // Two-flop synchroniser plus a delay flop, used to detect the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= bus.int_req;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // The event is the rising edge of the synchronised request.
   always_comb begin
      req_evt_s = s2_q & ~s3_q;
   end
`else
   // Two-flop synchroniser. The level itself is the event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= bus.int_req;
         s2_q <= s1_q;
      end
   end

   // The event is the synchronised request level.
   always_comb begin
      req_evt_s = s2_q;
   end
`endif

   // Next-state logic and redirect decode for the IDLE/PEND/SERVICE machine.
   always_comb begin
      state_d       = state_q;
      flag_d        = flag_q;
      epc_d         = epc_q;
      int_count_d   = int_count_q;
      int_take_s    = 1'b0;
      eret_take_s   = 1'b0;
      pc_redirect_s = 32'h0000_0000;

      case (state_q)
         ST_IDLE: begin
            // An eret in IDLE is ignored.
            if (req_evt_s) begin
               state_d = ST_PEND;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_PEND: begin
            // Wait for a committing instruction. There is no timeout, and an
            // eret here is ignored.
            if (bus.inst_valid) begin
               int_take_s    = 1'b1;
               pc_redirect_s = INT_VECTOR;
               epc_d         = bus.pc_next;
               int_count_d   = int_count_q + 16'd1;
               state_d       = ST_SERVICE;
            end else begin
               state_d       = ST_PEND;
            end
         end

         ST_SERVICE: begin
            if (bus.eret && bus.inst_valid) begin
               eret_take_s   = 1'b1;
               pc_redirect_s = epc_q;
               flag_d        = 1'b0;
               // A request merged during service, or one arriving now, is
               // served next.
               if (flag_q || req_evt_s) begin
                  state_d = ST_PEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               // No nesting: further events collapse into the single flag.
               flag_d  = flag_q | req_evt_s;
               state_d = ST_SERVICE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
         end
      endcase
   end

   // Controller state registers. Reset discards any pending or saved context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         flag_q      <= 1'b0;
         epc_q       <= 32'h0000_0000;
         int_count_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         flag_q      <= flag_d;
         epc_q       <= epc_d;
         int_count_q <= int_count_d;
      end
   end

   assign bus.int_code    = (state_q == ST_SERVICE);
   assign bus.int_take    = int_take_s;
   assign bus.eret_take   = eret_take_s;
   assign bus.pc_redirect = pc_redirect_s;
   assign bus.epc         = epc_q;
   assign bus.int_count   = int_count_q;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl: directed, self-checking bench for int_ctrl. The expectations
// follow the default level-sensitive build. Where edge mode behaves
// differently, INT_EDGE_EN selects the expected value.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_int_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   int_ctrl_if bus_if ();

   int_ctrl #(.INT_VECTOR(32'h0000_0004)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   // 100 MHz clock; rising edge active.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one active edge, then settle 2 ns into the cycle.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Watchdog so the bench always terminates.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n             = 1'b0;
      bus_if.int_req    = 1'b0;
      bus_if.inst_valid = 1'b0;
      bus_if.eret       = 1'b0;
      bus_if.pc_next    = 32'h0;

      // Reset state.
      tick();
      check_val("rst_int_code",  {31'd0, bus_if.int_code},  32'd0);
      check_val("rst_int_take",  {31'd0, bus_if.int_take},  32'd0);
      check_val("rst_eret_take", {31'd0, bus_if.eret_take}, 32'd0);
      check_val("rst_epc",       bus_if.epc,                32'd0);
      check_val("rst_count",     {16'd0, bus_if.int_count}, 32'd0);
      check_val("rst_redirect",  bus_if.pc_redirect,        32'd0);
      rst_n = 1'b1;
      tick();

      // First interrupt: a one-cycle request pulse, inst_valid held high.
      bus_if.inst_valid = 1'b1;
      bus_if.pc_next    = 32'h0000_0040;
      bus_if.int_req    = 1'b1;
      tick();                                   // E0
      bus_if.int_req    = 1'b0;
      #1 check_val("lat_e0_take", {31'd0, bus_if.int_take}, 32'd0);
      tick();                                   // E1
      check_val("lat_e1_take", {31'd0, bus_if.int_take}, 32'd0);
      tick();                                   // E2 -> PEND
      check_val("take1",       {31'd0, bus_if.int_take}, 32'd1);
      check_val("take1_redir", bus_if.pc_redirect,       32'h4);
      check_val("take1_eret",  {31'd0, bus_if.eret_take}, 32'd0);
      tick();                                   // SERVICE
      check_val("svc1_epc",    bus_if.epc,                32'h40);
      check_val("svc1_code",   {31'd0, bus_if.int_code},  32'd1);
      check_val("svc1_count",  {16'd0, bus_if.int_count}, 32'd1);
      check_val("svc1_take",   {31'd0, bus_if.int_take},  32'd0);
      check_val("svc1_redir",  bus_if.pc_redirect,        32'h0);

      // eret during service.
      bus_if.pc_next = 32'h0000_0080;
      bus_if.eret    = 1'b1;
      #1 check_val("eret1_take",  {31'd0, bus_if.eret_take}, 32'd1);
      check_val("eret1_redir", bus_if.pc_redirect,        32'h40);
      check_val("eret1_itake", {31'd0, bus_if.int_take},  32'd0);
      tick();
      bus_if.eret = 1'b0;
      #1 check_val("idle_code",   {31'd0, bus_if.int_code},  32'd0);
      check_val("idle_eret",   {31'd0, bus_if.eret_take}, 32'd0);

      // PEND stalled for 5 cycles, with an eret that must be ignored.
      bus_if.inst_valid = 1'b0;
      bus_if.int_req    = 1'b1;
      tick();
      bus_if.int_req    = 1'b0;
      tick();
      tick();                                   // now PEND
      bus_if.eret = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 check_val("stall_take", {31'd0, bus_if.int_take},  32'd0);
         check_val("stall_eret", {31'd0, bus_if.eret_take}, 32'd0);
         tick();
      end
      bus_if.eret = 1'b0;
      #1 check_val("stall_code", {31'd0, bus_if.int_code}, 32'd0);
      check_val("stall_epc",  bus_if.epc,               32'h40);
      bus_if.pc_next    = 32'h0000_0100;
      bus_if.inst_valid = 1'b1;
      #1 check_val("take2",       {31'd0, bus_if.int_take}, 32'd1);
      check_val("take2_redir", bus_if.pc_redirect,       32'h4);
      tick();
      check_val("svc2_epc",   bus_if.epc,                32'h100);
      check_val("svc2_count", {16'd0, bus_if.int_count}, 32'd2);

      // Second request during service is latched and served after eret.
      bus_if.inst_valid = 1'b0;
      bus_if.int_req    = 1'b1;
      tick();
      bus_if.int_req    = 1'b0;
      tick();
      tick();
      tick();
      check_val("nest_code", {31'd0, bus_if.int_code}, 32'd1);
      bus_if.eret       = 1'b1;
      bus_if.inst_valid = 1'b1;
      #1 check_val("eret2_take",  {31'd0, bus_if.eret_take}, 32'd1);
      check_val("eret2_itake", {31'd0, bus_if.int_take},  32'd0);
      check_val("eret2_redir", bus_if.pc_redirect,        32'h100);
      bus_if.pc_next = 32'h0000_0200;
      tick();                                   // PEND from the latched flag
      bus_if.eret = 1'b0;
      #1 check_val("pend3_code",  {31'd0, bus_if.int_code}, 32'd0);
      check_val("take3",       {31'd0, bus_if.int_take}, 32'd1);
      check_val("take3_redir", bus_if.pc_redirect,       32'h4);
      tick();
      check_val("svc3_count", {16'd0, bus_if.int_count}, 32'd3);
      check_val("svc3_epc",   bus_if.epc,                32'h200);

      // Asynchronous reset during service.
      rst_n = 1'b0;
      #1 check_val("arst_code",  {31'd0, bus_if.int_code},  32'd0);
      check_val("arst_count", {16'd0, bus_if.int_count}, 32'd0);
      check_val("arst_epc",   bus_if.epc,                32'd0);
      bus_if.eret = 1'b1;
      #1 check_val("arst_eret", {31'd0, bus_if.eret_take}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check_val("post_rst_eret", {31'd0, bus_if.eret_take}, 32'd0);
      check_val("post_rst_code", {31'd0, bus_if.int_code},  32'd0);
      bus_if.eret = 1'b0;

      // Counter wrap and re-entry with the request held high.
      force dut.int_count_q = 16'hFFFF;
      #1 release dut.int_count_q;
      #1 check_val("preload", {16'd0, bus_if.int_count}, 32'h0000_FFFF);
      bus_if.int_req = 1'b1;
      tick();                                   // E0
      tick();                                   // E1
      tick();                                   // E2 -> PEND
      check_val("take4", {31'd0, bus_if.int_take}, 32'd1);
      tick();
      check_val("wrap_count", {16'd0, bus_if.int_count}, 32'd0);
      check_val("wrap_code",  {31'd0, bus_if.int_code},  32'd1);
      tick();
      bus_if.eret = 1'b1;
      #1 check_val("eret4_take", {31'd0, bus_if.eret_take}, 32'd1);
      tick();
      bus_if.eret = 1'b0;
`ifdef INT_EDGE_EN
      #1 check_val("held_take", {31'd0, bus_if.int_take}, 32'd0);
`else
      #1 check_val("held_take", {31'd0, bus_if.int_take}, 32'd1);
`endif
      check_val("held_code", {31'd0, bus_if.int_code}, 32'd0);
      bus_if.int_req    = 1'b0;
      bus_if.inst_valid = 1'b0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
